// File: rtl/img_window_engine.sv
// img_window_engine: windowed view over a ROWS x COLS x depth pixel map.
// Supports bulk load, origin/depth moves, windowed display and channel sums.
module img_window_engine #(
  parameter int DW        = 8,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int DEPTH_MAX = 32,
  parameter int DEPTH_MIN = 8,
  parameter int WIN       = 2,
  parameter int OW        = 14
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_op_valid,
  input  logic [3:0]    i_op_mode,
  output logic          o_op_ready,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [OW-1:0] o_out_data,
  output logic          o_op_err
);

  localparam int NPIX = ROWS * COLS * DEPTH_MAX;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = $clog2(COLS + 1);
  localparam int YW   = $clog2(ROWS + 1);
  localparam int IW   = $clog2(WIN + 1);
  localparam int ZW   = $clog2(DEPTH_MAX + 1);

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_RIGHT = 4'd1;
  localparam logic [3:0] OP_LEFT  = 4'd2;
  localparam logic [3:0] OP_UP    = 4'd3;
  localparam logic [3:0] OP_DOWN  = 4'd4;
  localparam logic [3:0] OP_SDOWN = 4'd5;
  localparam logic [3:0] OP_SUP   = 4'd6;
  localparam logic [3:0] OP_DISP  = 4'd7;
  localparam logic [3:0] OP_SUM   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_DISP, S_SUM
  } state_t;

  state_t        r_state;
  logic [3:0]    r_mode;
  logic          r_op_ready;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [OW-1:0] r_out_data;
  logic          r_op_err;
  logic [AW-1:0] r_cnt;
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic [ZW-1:0] r_depth;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [ZW-1:0] r_z;
  logic          r_issuing;
  logic          r_rd_v;
  logic          r_rd_last;
  logic [OW-1:0] r_acc;
  logic [DW-1:0] r_rd;
  logic [DW-1:0] r_mem [NPIX];

  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic          w_ilast;
  logic          w_jlast;
  logic          w_zlast;

  assign w_ilast = (r_i == IW'(WIN - 1));
  assign w_jlast = (r_j == IW'(WIN - 1));
  assign w_zlast = (r_z == r_depth - ZW'(1));
  assign w_we    = r_in_ready && i_in_valid;

  always_comb begin
    w_px   = r_ox + XW'(r_i);
    w_py   = r_oy + YW'(r_j);
    w_addr = AW'(r_z) * AW'(ROWS * COLS)
           + AW'(w_py) * AW'(COLS) + AW'(w_px);
    if (r_state == S_LOAD) w_addr = r_cnt;
  end

  // Pixel store: no reset, one-cycle read.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_addr] <= i_in_data;
    r_rd <= r_mem[w_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_op_ready  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_op_err    <= 1'b0;
      r_cnt       <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_depth     <= ZW'(DEPTH_MAX);
      r_i         <= '0;
      r_j         <= '0;
      r_z         <= '0;
      r_issuing   <= 1'b0;
      r_rd_v      <= 1'b0;
      r_rd_last   <= 1'b0;
      r_acc       <= '0;
    end else begin
      r_op_err    <= 1'b0;
      r_rd_v      <= r_issuing;
      r_rd_last   <= (r_state == S_DISP) || w_zlast;
      r_out_valid <= r_rd_v && r_rd_last;
      // Display passes each word through; sum closes on the last channel.
      if (r_rd_v) begin
        if (r_rd_last) begin
          r_out_data <= r_acc + OW'(r_rd);
          r_acc      <= '0;
        end else begin
          r_acc <= r_acc + OW'(r_rd);
        end
      end
      if (r_issuing) begin
        if (r_state == S_DISP) begin
          if (w_ilast) begin
            r_i <= '0;
            if (w_jlast) begin
              r_j <= '0;
              r_z <= r_z + ZW'(1);
            end else begin
              r_j <= r_j + IW'(1);
            end
          end else begin
            r_i <= r_i + IW'(1);
          end
        end else begin
          if (w_zlast) begin
            r_z <= '0;
            if (w_ilast) begin
              r_i <= '0;
              r_j <= r_j + IW'(1);
            end else begin
              r_i <= r_i + IW'(1);
            end
          end else begin
            r_z <= r_z + ZW'(1);
          end
        end
        if (w_ilast && w_jlast && w_zlast) begin
          r_issuing <= 1'b0;
          r_i       <= '0;
          r_j       <= '0;
          r_z       <= '0;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          r_op_ready <= 1'b1;
          if (i_op_valid && r_op_ready) begin
            r_op_ready <= 1'b0;
            r_mode     <= i_op_mode;
            unique case (1'b1)
              (i_op_mode == OP_LOAD): begin
                r_state    <= S_LOAD;
                r_in_ready <= 1'b1;
                r_cnt      <= '0;
              end
              (i_op_mode == OP_DISP),
              (i_op_mode == OP_SUM): begin
                r_state   <= (i_op_mode == OP_DISP) ? S_DISP : S_SUM;
                r_issuing <= 1'b1;
                r_i       <= '0;
                r_j       <= '0;
                r_z       <= '0;
                r_acc     <= '0;
              end
              default: begin
                r_state  <= S_EXEC;
                r_op_err <= (i_op_mode > OP_SUM);
              end
            endcase
          end
        end
        S_LOAD: begin
          if (i_in_valid) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == AW'(NPIX - 1)) begin
              r_in_ready <= 1'b0;
              r_op_ready <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_IDLE;
            end
          end
        end
        S_EXEC: begin
          case (r_mode)
            OP_RIGHT: if (r_ox < XW'(COLS - WIN)) r_ox <= r_ox + XW'(1);
            OP_LEFT:  if (r_ox != '0) r_ox <= r_ox - XW'(1);
            OP_DOWN:  if (r_oy < YW'(ROWS - WIN)) r_oy <= r_oy + YW'(1);
            OP_UP:    if (r_oy != '0) r_oy <= r_oy - YW'(1);
            OP_SDOWN: if (r_depth > ZW'(DEPTH_MIN)) r_depth <= r_depth >> 1;
            OP_SUP:   if (r_depth < ZW'(DEPTH_MAX)) r_depth <= r_depth << 1;
            default: ;
          endcase
          r_op_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_DISP, S_SUM: begin
          if (!r_issuing && !r_rd_v && r_out_valid) begin
            r_op_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_op_ready  = r_op_ready;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_op_err    = r_op_err;

endmodule

// File: tb/tb_img_window_engine.sv
// tb_img_window_engine: table-driven directed checks of img_window_engine,
// plus hand-written reset and load sequences.
module tb_img_window_engine;
  localparam int DW = 8, ROWS = 8, COLS = 8;
  localparam int DMAX = 32, DMIN = 8, WIN = 2, OW = 14;
  localparam int NPIX = ROWS * COLS * DMAX;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          op_valid = 1'b0;
  logic [3:0]    op_mode = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          op_ready, in_ready, out_valid, op_err;
  logic [OW-1:0] out_data;

  img_window_engine #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .DEPTH_MAX(DMAX),
    .DEPTH_MIN(DMIN), .WIN(WIN), .OW(OW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_op_valid(op_valid), .i_op_mode(op_mode), .o_op_ready(op_ready),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mode;
    int rep;
    int ox;
    int oy;
    int dep;
    int nout;
    int first;
    int err;
  } vec_t;

  vec_t tbl[$];
  int   q_data[$];
  int   q_e[$];
  int   g_nerr, g_ready_e;
  int   checks = 0, errors = 0;
  bit   ramp = 1'b1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int pix(int x, int y, int z);
    return ramp ? ((z * ROWS * COLS + y * COLS + x) & 255) : 255;
  endfunction

  function automatic int exp_word(vec_t v, int k);
    int s;
    s = 0;
    if (v.mode == 4'd7)
      return pix(v.ox + k % WIN, v.oy + (k / WIN) % WIN, k / (WIN * WIN));
    for (int z = 0; z < v.dep; z++)
      s += pix(v.ox + k % WIN, v.oy + k / WIN, z);
    return s;
  endfunction

  function automatic vec_t mk(int m, int rep, int ox, int oy, int dep,
                              int nout, int first, int err);
    vec_t v;
    v.mode = 4'(m); v.rep = rep; v.ox = ox; v.oy = oy;
    v.dep = dep; v.nout = nout; v.first = first; v.err = err;
    return v;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      checks++; errors++;
      $display("FAIL wait_ready timeout got 0 expected 1");
    end
  endtask

  task automatic accept(input logic [3:0] m);
    wait_ready();
    op_valid = 1'b1;
    op_mode  = m;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_mode  = 4'd12;
  endtask

  task automatic run_op(input logic [3:0] m);
    accept(m);
    q_data.delete();
    q_e.delete();
    g_nerr = 0;
    g_ready_e = -1;
    for (int e = 0; e < 3000; e++) begin
      if (op_err) g_nerr++;
      if (out_valid) begin
        q_data.push_back(int'(out_data));
        q_e.push_back(e);
      end
      if (e > 0 && op_ready) begin
        g_ready_e = e;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (g_ready_e < 0) begin
      checks++; errors++;
      $display("FAIL op_timeout mode %0d got no ready expected ready", m);
    end
  endtask

  task automatic load(input bit fill_ramp);
    int idx, n;
    bit held, rdy;
    ramp = fill_ramp;
    accept(4'd0);
    idx = 0; n = 0; held = 1'b1;
    while (idx < NPIX && n < 20000) begin
      @(negedge clk);
      rdy = in_ready;
      if (!rdy) held = 1'b0;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = fill_ramp ? DW'(idx & 255) : 8'hff;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      n++;
    end
    @(negedge clk);
    chk("load_in_ready_held", int'(held), 1);
    chk("load_words", idx, NPIX);
    chk("load_in_ready_drop", int'(in_ready), 0);
    chk("load_op_ready_back", int'(op_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic check_op(input vec_t v);
    int n, bad, bad2, step, lat;
    if (v.nout == 0) begin
      chk("exec_ready_latency", g_ready_e, 1);
      chk("exec_err_pulses", g_nerr, v.err);
    end else begin
      n = q_data.size();
      step = (v.mode == 4'd7) ? 1 : v.dep;
      lat  = (v.mode == 4'd7) ? 2 : v.dep + 1;
      chk("out_count", n, v.nout);
      chk("first_word", n > 0 ? q_data[0] : -1, v.first);
      bad = 0; bad2 = 0;
      for (int k = 0; k < n; k++) begin
        if (k < v.nout && q_data[k] != exp_word(v, k)) bad++;
        if (q_e[k] != lat + k * step) bad2++;
      end
      chk("words_bad", bad, 0);
      chk("first_valid_latency", n > 0 ? q_e[0] : -1, lat);
      chk("output_spacing_bad", bad2, 0);
      chk("ready_after_last", g_ready_e, lat + (v.nout - 1) * step + 1);
      chk("err_pulses", g_nerr, 0);
    end
  endtask

  initial begin
    int n, e;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 1, 0, 0, 32, 128, 0, 0));
    tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 1, 6, 6, 32, 128, 54, 0));
    tbl.push_back(mk(5, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 1, 6, 6, 8, 32, 54, 0));
    tbl.push_back(mk(6, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 1, 6, 6, 32, 128, 54, 0));
    tbl.push_back(mk(12, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(7, 1, 6, 6, 32, 128, 54, 0));
    tbl.push_back(mk(2, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 32, 4, 3072, 0));
    tbl.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 16, 4, 1536, 0));
    tbl.push_back(mk(6, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 1, 1, 0, 32, 128, 1, 0));
    tbl.push_back(mk(15, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 32, 4, 8160, 0));
    tbl.push_back(mk(5, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 8, 4, 2040, 0));
    tbl.push_back(mk(9, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6, 3, 0, 0, 0, 0, 0, 0));

    #2 rst_n = 1'b0;
    #10;
    chk("rst_op_ready", int'(op_ready), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_op_err", int'(op_err), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_ready_low", int'(op_ready), 0);
    @(posedge clk);
    #1 chk("ready_first_edge", int'(op_ready), 1);

    foreach (tbl[t]) begin
      if (tbl[t].mode == 4'd0) begin
        load(tbl[t].rep == 0);
      end else begin
        for (int r = 0; r < tbl[t].rep; r++) begin
          run_op(tbl[t].mode);
          check_op(tbl[t]);
        end
      end
    end

    // Reset in the middle of a display, with origin and depth moved.
    load(1'b1);
    run_op(4'd1);
    run_op(4'd5);
    accept(4'd7);
    n = 0; e = 0;
    while (n < 40 && e < 1000) begin
      if (out_valid) n++;
      if (n < 40) begin
        @(posedge clk);
        #1;
        e++;
      end
    end
    chk("mid_disp_outputs", n, 40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_op_ready", int'(op_ready), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("mid_rst_ready_first_edge", int'(op_ready), 1);
    #1 chk("mid_rst_no_output", int'(out_valid), 0);
    load(1'b1);
    run_op(4'd7);
    check_op(mk(7, 1, 0, 0, 32, 128, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/img_window_engine.md
IMG_WINDOW_ENGINE -- requirements
Module: img_window_engine

Interface
REQ-001 Parameter DW, 8, pixel data width in bits.
REQ-002 Parameter ROWS, 8, image map rows.
REQ-003 Parameter COLS, 8, image map columns.
REQ-004 Parameter DEPTH_MAX, 32, maximum channel depth; power of two.
REQ-005 Parameter DEPTH_MIN, 8, minimum channel depth; power of two, at most DEPTH_MAX.
REQ-006 Parameter WIN, 2, square window edge; at least 1, at most min(ROWS,COLS).
REQ-007 Parameter OW, 14, output width; at least DW+clog2(DEPTH_MAX).
REQ-008 Clock and reset shall be: reset i_rst_n, asynchronous, active-low; clock i_clk.
REQ-009 i_clk  in  1  clock, all logic rising-edge.
REQ-010 i_rst_n  in  1  asynchronous active-low reset.
REQ-011 i_op_valid  in  1  operation request strobe.
REQ-012 i_op_mode  in  4  operation code.
REQ-013 o_op_ready  out  1  engine idle, operation may be accepted.
REQ-014 i_in_valid  in  1  load data valid.
REQ-015 i_in_data  in  DW  load pixel.
REQ-016 o_in_ready  out  1  load data accepted this cycle if i_in_valid.
REQ-017 o_out_valid  out  1  o_out_data valid this cycle.
REQ-018 o_out_data  out  OW  result, zero-extended.
REQ-019 o_op_err  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-020 Internal memory shall hold ROWS*COLS*DEPTH_MAX words of DW bits; address = z*ROWS*COLS + y*COLS + x; read latency is 1 cycle; no reset of contents.
REQ-021 FSM states shall be IDLE, LOAD, EXEC, DISP, SUM; o_op_ready=1 only in IDLE; an op is accepted when i_op_valid and o_op_ready are both high on a rising edge; i_op_mode is sampled at that edge only.
REQ-022 Opcodes: 0 load, 1 shift right, 2 shift left, 3 shift up, 4 shift down, 5 scale down, 6 scale up, 7 display, 8 channel sum; 9-15 unsupported.
REQ-023 Load: LOAD asserts o_in_ready; each cycle with i_in_valid high writes i_in_data at address cnt and increments cnt; after ROWS*COLS*DEPTH_MAX writes, o_in_ready drops and FSM returns to IDLE next cycle; gaps in i_in_valid stall without loss.
REQ-024 Shift ops shall move origin (ox,oy) by one: right ox+1, left ox-1, down oy+1, up oy-1; saturating at 0 and at COLS-WIN / ROWS-WIN (no wrap).
REQ-025 Scale down shall halve depth, saturating at DEPTH_MIN; scale up shall double depth, saturating at DEPTH_MAX.
REQ-026 Shift, scale and unsupported ops take EXEC for exactly 1 cycle; o_op_ready low for 1 cycle, then high.
REQ-027 Unsupported opcode shall pulse o_op_err in the EXEC cycle and change no state.
REQ-028 Display shall emit WIN*WIN*depth words, order z outer, then y, then x: pixel(ox+i, oy+j, z), one per cycle, no gaps.
REQ-029 Display: first o_out_valid is 2 cycles after the accept edge; o_op_ready rises the cycle after the last valid.
REQ-030 Channel sum shall emit WIN*WIN words, row-major (j outer, i inner); each is the sum over z=0..depth-1 of pixel(ox+i,oy+j,z), full precision, no overflow within OW.
REQ-031 Channel sum: one memory read per cycle; each result valid for 1 cycle on the cycle after its last read returns; next window position's reads follow back-to-back; o_op_ready rises the cycle after the final valid.
REQ-032 o_out_valid shall be low in all states except valid cycles of DISP/SUM; o_out_data holds its last value when not valid.
REQ-033 i_in_valid outside LOAD and i_op_valid while o_op_ready is low shall be ignored.

Reset
REQ-034 Reset asserted at any time, including mid-LOAD, DISP or SUM, shall immediately force IDLE, origin (0,0), depth DEPTH_MAX, cnt 0, and o_op_ready, o_in_ready, o_out_valid, o_op_err, o_out_data all 0.
REQ-035 o_op_ready shall be 0 while in reset and 1 on the first rising edge after release.
REQ-036 An operation interrupted by reset shall be abandoned with no further outputs; memory contents are undefined.

Verification
REQ-037 Load 2048 bytes with value = addr[7:0] and random i_in_valid gaps, then display -> 128 words 0,1,8,9,64,65,72,73,... with no gaps; first valid 2 cycles after accept.
REQ-038 Shift right 10x, shift down 10x, then display -> origin saturated at (6,6); first word = 54.
REQ-039 Scale down 3x, then display -> 32 outputs (depth saturated at 8); scale up 3x, then display -> 128 outputs.
REQ-040 Load all bytes 255, depth 32, channel sum -> 4 outputs of 8160; depth 8 -> 4 outputs of 2040.
REQ-041 Opcode 12 -> o_op_err pulses for 1 cycle, o_op_ready low for 1 cycle, origin and depth unchanged.
REQ-042 Assert reset at the 40th display output -> o_out_valid 0 at once; o_op_ready 1 on first edge after release; next display starts at origin (0,0) with 128 outputs.
